// File: rtl/computie_bus_pkg.sv
// Shared encodings for the Computie bus tracer: FSM states, flag-byte layout,
// trigger modes and the per-entry byte count of the dump stream.
package computie_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_POST,
        ST_DONE,
        ST_DUMP
    } state_e;

    // Flag byte is {kind, rw, berr, 5'b0}; kind 0 = address entry, 1 = data entry.
    localparam int FLAG_KIND = 7;
    localparam int FLAG_RW   = 6;
    localparam int FLAG_BERR = 5;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_ADDR      = 2'd1;
    localparam logic [1:0] TRIG_EXT       = 2'd2;
    localparam logic [1:0] TRIG_BERR      = 2'd3;

    function automatic int ENTRY_BYTES(input int bitwidth);
        return 1 + bitwidth / 8;
    endfunction

endpackage

// File: rtl/bus_edge_sync.sv
// Two-flop synchronisers for the asynchronous bus controls, plus one-cycle
// address (AS falling) and data (first DS+DSACK per AS cycle) event pulses.
module bus_edge_sync (
    input  logic comm_clock,
    input  logic reset,
    input  logic cb_addr_strobe,
    input  logic cb_data_strobe,
    input  logic cb_read_write,
    input  logic cb_dsack0,
    input  logic cb_dsack1,
    input  logic cb_berr,
    output logic addr_event,
    output logic data_event,
    output logic rw,
    output logic berr
);

    // Bit order: {berr, dsack1, dsack0, rw, ds, as}; all idle high.
    logic [5:0] meta;
    logic [5:0] sync;
    logic       as_prev;
    logic       data_seen;

    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            meta      <= '1;
            sync      <= '1;
            as_prev   <= 1'b1;
            data_seen <= 1'b0;
        end else begin
            meta    <= {cb_berr, cb_dsack1, cb_dsack0, cb_read_write, cb_data_strobe, cb_addr_strobe};
            sync    <= meta;
            as_prev <= sync[0];
            if (sync[0])
                data_seen <= 1'b0;
            else if (data_event)
                data_seen <= 1'b1;
        end
    end

    // A data phase coinciding with the address edge is deferred one cycle.
    assign addr_event = as_prev & ~sync[0];
    assign data_event = ~sync[0] & ~addr_event & ~sync[1] & ~(sync[3] & sync[4]) & ~data_seen;
    assign rw         = sync[2];
    assign berr       = ~sync[5];

endmodule

// File: rtl/computie_bus_tracer.sv
// Triggered circular-buffer tracer for the Computie bus; the captured window
// is replayed as a byte stream (flag byte, then AD word MSB-first) on demand.
module computie_bus_tracer
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH    = 32,
    parameter int DEPTH       = 64,
    parameter int PRE_TRIGGER = 16
) (
    input  logic                       comm_clock,
    input  logic                       reset,
    input  logic                       arm,
    input  logic [1:0]                 trig_mode,
    input  logic                       trig_ext,
    input  logic [BITWIDTH-1:0]        match_addr,
    input  logic [BITWIDTH-1:0]        match_mask,
    input  logic                       dump_start,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    input  logic                       cb_clk,
    input  logic                       cb_addr_strobe,
    input  logic                       cb_data_strobe,
    input  logic                       cb_read_write,
    input  logic                       cb_dsack0,
    input  logic                       cb_dsack1,
    input  logic                       cb_berr,
    input  logic [BITWIDTH-1:0]        cb_addr_data_bus,
    output logic                       armed,
    output logic                       triggered,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     entry_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = BITWIDTH + 8;
    localparam int NB = ENTRY_BYTES(BITWIDTH);
    localparam int BW = $clog2(NB);
    localparam logic [CW-1:0] PRE_MAX   = CW'(PRE_TRIGGER);
    localparam logic [CW-1:0] POST_LEN  = CW'(DEPTH - PRE_TRIGGER);
    localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIGGER - 1);
    localparam logic [CW-1:0] ONE_LEFT  = CW'(1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    // Events are timed off the strobes, so the bus clock is not needed.
    logic unused_cb_clk;
    assign unused_cb_clk = cb_clk;

    logic addr_event, data_event, ev_rw, ev_berr, ev_hit;
    logic [EW-1:0] ev_entry;

    bus_edge_sync u_sync (
        .comm_clock     (comm_clock),
        .reset          (reset),
        .cb_addr_strobe (cb_addr_strobe),
        .cb_data_strobe (cb_data_strobe),
        .cb_read_write  (cb_read_write),
        .cb_dsack0      (cb_dsack0),
        .cb_dsack1      (cb_dsack1),
        .cb_berr        (cb_berr),
        .addr_event     (addr_event),
        .data_event     (data_event),
        .rw             (ev_rw),
        .berr           (ev_berr)
    );

    assign ev_hit   = addr_event | data_event;
    assign ev_entry = {data_event, ev_rw, ev_berr, 5'b0, cb_addr_data_bus};

    state_e          state, state_n;
    logic [AW-1:0]   wr_ptr, trig_idx, rd_addr;
    logic [CW-1:0]   pre_cnt, post_cnt, ent_left;
    logic [BW-1:0]   byte_idx;
    logic [BITWIDTH-1:0] sh_word;
    logic [EW-1:0]   rd_q;
    logic            loading, priming;
    logic            fire, wr_en, restart, dump_last;

    logic [EW-1:0] mem [DEPTH];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        fire = 1'b0;
        case (trig_mode)
            TRIG_IMMEDIATE: fire = 1'b1;
            TRIG_ADDR:      fire = addr_event &&
                                   ((cb_addr_data_bus & match_mask) == (match_addr & match_mask));
            TRIG_EXT:       fire = trig_ext;
            default:        fire = ev_berr;
        endcase
        fire = fire & ev_hit;
    end

    assign restart   = arm && (state != ST_DUMP);
    assign dump_last = out_valid && out_ready && !loading && (byte_idx == LAST_BYTE) && (ent_left == ONE_LEFT);

    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        case (state)
            ST_IDLE: if (arm) state_n = ST_FILL;
            ST_FILL: begin
                if (arm) begin
                    state_n = ST_FILL;
                end else if (ev_hit) begin
                    wr_en = 1'b1;
                    if (fire) state_n = (POST_LEN == ONE_LEFT) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (arm) begin
                    state_n = ST_FILL;
                end else if (ev_hit) begin
                    wr_en = 1'b1;
                    if (post_cnt == POST_LAST) state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm)             state_n = ST_FILL;
                else if (dump_start) state_n = ST_DUMP;
            end
            ST_DUMP: if (dump_last) state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge comm_clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            trig_idx    <= '0;
            rd_addr     <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            ent_left    <= '0;
            byte_idx    <= '0;
            sh_word     <= '0;
            loading     <= 1'b0;
            priming     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            done        <= 1'b0;
            entry_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state     <= state_n;
            armed     <= state_n inside {ST_FILL, ST_POST};
            triggered <= state_n inside {ST_POST, ST_DONE, ST_DUMP};
            done      <= state_n inside {ST_DONE, ST_DUMP};

            if (restart) begin
                wr_ptr      <= '0;
                pre_cnt     <= '0;
                post_cnt    <= '0;
                entry_count <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (state == ST_FILL && fire) begin
                    trig_idx <= wr_ptr;
                    post_cnt <= ONE_LEFT;
                end else if (state == ST_FILL) begin
                    if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 1'b1;
                end else begin
                    post_cnt <= post_cnt + 1'b1;
                end
                if (state_n == ST_DONE) entry_count <= pre_cnt + POST_LEN;
            end

            // Dump: one priming cycle for the first read, then rd_addr runs one entry ahead.
            if (state == ST_DONE && state_n == ST_DUMP) begin
                rd_addr  <= trig_idx - pre_cnt[AW-1:0];
                ent_left <= entry_count;
                loading  <= 1'b1;
                priming  <= 1'b1;
            end else if (state == ST_DUMP) begin
                if (loading) begin
                    if (priming) begin
                        priming <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= rd_q[EW-1 -: 8];
                        sh_word   <= rd_q[BITWIDTH-1:0];
                        byte_idx  <= '0;
                        loading   <= 1'b0;
                        rd_addr   <= rd_addr + 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    if (byte_idx == LAST_BYTE) begin
                        out_valid <= 1'b0;
                        ent_left  <= ent_left - 1'b1;
                        if (ent_left != ONE_LEFT) loading <= 1'b1;
                    end else begin
                        out_data <= sh_word[BITWIDTH-1 -: 8];
                        sh_word  <= sh_word << 8;
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: the trace RAM has no reset; its contents are only meaningful once a capture completes.
    always_ff @(posedge comm_clock) begin
        if (wr_en) mem[wr_ptr] <= ev_entry;
        rd_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_computie_bus_tracer.sv
// Directed bench for computie_bus_tracer (DEPTH=8, PRE_TRIGGER=2, 32-bit AD):
// trigger modes 0/1/3, stalled dump, re-arm, dump gating and async reset.
module tb_computie_bus_tracer;

    localparam int BITWIDTH    = 32;
    localparam int DEPTH       = 8;
    localparam int PRE_TRIGGER = 2;

    logic        comm_clock;
    logic        reset;
    logic        arm;
    logic [1:0]  trig_mode;
    logic        trig_ext;
    logic [31:0] match_addr, match_mask;
    logic        dump_start;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        cb_clk, cb_addr_strobe, cb_data_strobe, cb_read_write;
    logic        cb_dsack0, cb_dsack1, cb_berr;
    logic [31:0] cb_addr_data_bus;
    logic        armed, triggered, done;
    logic [3:0]  entry_count;

    int n_checks;
    int n_errors;
    logic [7:0] got[$];
    logic [7:0] exp_bytes[$];

    computie_bus_tracer #(
        .BITWIDTH    (BITWIDTH),
        .DEPTH       (DEPTH),
        .PRE_TRIGGER (PRE_TRIGGER)
    ) dut (
        .comm_clock       (comm_clock),
        .reset            (reset),
        .arm              (arm),
        .trig_mode        (trig_mode),
        .trig_ext         (trig_ext),
        .match_addr       (match_addr),
        .match_mask       (match_mask),
        .dump_start       (dump_start),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .cb_clk           (cb_clk),
        .cb_addr_strobe   (cb_addr_strobe),
        .cb_data_strobe   (cb_data_strobe),
        .cb_read_write    (cb_read_write),
        .cb_dsack0        (cb_dsack0),
        .cb_dsack1        (cb_dsack1),
        .cb_berr          (cb_berr),
        .cb_addr_data_bus (cb_addr_data_bus),
        .armed            (armed),
        .triggered        (triggered),
        .done             (done),
        .entry_count      (entry_count)
    );

    initial comm_clock = 1'b0;
    always #5 comm_clock = ~comm_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge comm_clock);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_dump();
        dump_start = 1'b1;
        tick(1);
        dump_start = 1'b0;
    endtask

    // One bus cycle: address phase, then data phase with DSACK0 (and BERR if asked).
    task automatic bus_cycle(input logic [31:0] addr, input logic [31:0] data,
                             input logic rw, input logic with_berr);
        cb_addr_data_bus = addr;
        cb_read_write    = rw;
        cb_addr_strobe   = 1'b0;
        tick(4);
        cb_addr_data_bus = data;
        cb_data_strobe   = 1'b0;
        cb_dsack0        = 1'b0;
        cb_berr          = ~with_berr;
        tick(4);
        cb_addr_strobe   = 1'b1;
        cb_data_strobe   = 1'b1;
        cb_dsack0        = 1'b1;
        cb_berr          = 1'b1;
        tick(3);
    endtask

    task automatic push_entry(input logic [7:0] flag, input logic [31:0] word);
        exp_bytes.push_back(flag);
        for (int i = 3; i >= 0; i--) exp_bytes.push_back(word[i*8 +: 8]);
    endtask

    task automatic run_dump(input int n_bytes, input bit random_ready, input string tag);
        int         cyc;
        int         stall_viol;
        logic       prev_stall;
        logic [7:0] prev_data;
        got.delete();
        cyc        = 0;
        stall_viol = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        pulse_dump();
        while (got.size() < n_bytes && cyc < 2000) begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_viol++;
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data  = out_data;
            tick(1);
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_len"}, 64'(got.size()), 64'(n_bytes));
        check({tag, "_stall_stable"}, 64'(stall_viol), 64'd0);
        tick(3);
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, "_done_after"}, 64'(done), 64'd1);
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_bytes[i]));
    endtask

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        reset            = 1'b0;
        arm              = 1'b0;
        trig_mode        = 2'd0;
        trig_ext         = 1'b0;
        match_addr       = '0;
        match_mask       = '0;
        dump_start       = 1'b0;
        out_ready        = 1'b1;
        cb_clk           = 1'b1;
        cb_addr_strobe   = 1'b1;
        cb_data_strobe   = 1'b1;
        cb_read_write    = 1'b1;
        cb_dsack0        = 1'b1;
        cb_dsack1        = 1'b1;
        cb_berr          = 1'b1;
        cb_addr_data_bus = '0;

        // Reset state
        tick(2);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_data",    64'(out_data),    64'd0);
        check("rst_armed",       64'(armed),       64'd0);
        check("rst_triggered",   64'(triggered),   64'd0);
        check("rst_done",        64'(done),        64'd0);
        check("rst_entry_count", 64'(entry_count), 64'd0);
        reset = 1'b1;
        tick(2);

        // Mode 0: immediate trigger, 10 write cycles, 6 entries kept
        trig_mode = 2'd0;
        pulse_arm();
        check("t1_armed", 64'(armed), 64'd1);
        check("t1_not_trig", 64'(triggered), 64'd0);
        for (int n = 0; n < 10; n++)
            bus_cycle(32'h1000 + 32'(4 * n), 32'hDA00_0000 | 32'(n), 1'b0, 1'b0);
        check("t1_done", 64'(done), 64'd1);
        check("t1_triggered", 64'(triggered), 64'd1);
        check("t1_armed_clear", 64'(armed), 64'd0);
        check("t1_entry_count", 64'(entry_count), 64'd6);
        exp_bytes.delete();
        for (int n = 0; n < 3; n++) begin
            push_entry(8'h00, 32'h1000 + 32'(4 * n));
            push_entry(8'h80, 32'hDA00_0000 | 32'(n));
        end
        run_dump(30, 1'b0, "t1");
        check("t1_first_entry", {got[0], got[1], got[2], got[3], got[4]}, 64'h00_0000_1000);

        // Same trace again with random back-pressure
        run_dump(30, 1'b1, "t4");

        // Mode 1: address match, 8 read cycles before 0x2004
        trig_mode  = 2'd1;
        match_addr = 32'h0000_2000;
        match_mask = 32'hFFFF_F000;
        pulse_arm();
        check("t2_rearm_count", 64'(entry_count), 64'd0);
        check("t2_rearm_done", 64'(done), 64'd0);
        for (int n = 0; n < 8; n++)
            bus_cycle(32'h1000 + 32'(4 * n), 32'h5A00_0000 | 32'(n), 1'b1, 1'b0);
        check("t2_no_early_trig", 64'(triggered), 64'd0);
        for (int k = 0; k < 3; k++)
            bus_cycle(32'h2004 + 32'(4 * k), 32'h5B00_0000 | 32'(k), 1'b1, 1'b0);
        check("t2_done", 64'(done), 64'd1);
        check("t2_entry_count", 64'(entry_count), 64'd8);
        exp_bytes.delete();
        push_entry(8'h40, 32'h0000_101C);
        push_entry(8'hC0, 32'h5A00_0007);
        for (int k = 0; k < 3; k++) begin
            push_entry(8'h40, 32'h2004 + 32'(4 * k));
            push_entry(8'hC0, 32'h5B00_0000 | 32'(k));
        end
        run_dump(40, 1'b0, "t2");

        // Mode 3: bus error on the third cycle's data phase
        trig_mode = 2'd3;
        pulse_arm();
        bus_cycle(32'h3000, 32'h1111_1111, 1'b0, 1'b0);
        bus_cycle(32'h3004, 32'h2222_2222, 1'b0, 1'b0);
        cb_addr_data_bus = 32'h3008;
        cb_read_write    = 1'b0;
        cb_addr_strobe   = 1'b0;
        tick(4);
        cb_addr_data_bus = 32'h3333_3333;
        cb_data_strobe   = 1'b0;
        cb_dsack0        = 1'b0;
        cb_berr          = 1'b0;
        repeat (2) @(posedge comm_clock);
        #1;
        check("t3_trig_not_yet", 64'(triggered), 64'd0);
        @(posedge comm_clock);
        #1;
        check("t3_trig_at_3", 64'(triggered), 64'd1);
        tick(4);
        cb_addr_strobe = 1'b1;
        cb_data_strobe = 1'b1;
        cb_dsack0      = 1'b1;
        cb_berr        = 1'b1;
        tick(3);
        bus_cycle(32'h300C, 32'h4444_4444, 1'b0, 1'b0);
        bus_cycle(32'h3010, 32'h5555_5555, 1'b0, 1'b0);
        bus_cycle(32'h3014, 32'h6666_6666, 1'b0, 1'b0);
        check("t3_done", 64'(done), 64'd1);
        check("t3_entry_count", 64'(entry_count), 64'd8);
        exp_bytes.delete();
        push_entry(8'h80, 32'h2222_2222);
        push_entry(8'h00, 32'h0000_3008);
        push_entry(8'hA0, 32'h3333_3333);
        push_entry(8'h00, 32'h0000_300C);
        push_entry(8'h80, 32'h4444_4444);
        push_entry(8'h00, 32'h0000_3010);
        push_entry(8'h80, 32'h5555_5555);
        push_entry(8'h00, 32'h0000_3014);
        run_dump(40, 1'b0, "t3");
        check("t3_trig_flag", 64'(got[10]), 64'hA0);

        // Re-arm during POST, then dump_start while filling is ignored
        trig_mode = 2'd0;
        pulse_arm();
        bus_cycle(32'h4000, 32'h7777_7777, 1'b0, 1'b0);
        check("t5_in_post_trig", 64'(triggered), 64'd1);
        check("t5_in_post_armed", 64'(armed), 64'd1);
        pulse_arm();
        check("t5_restart_armed", 64'(armed), 64'd1);
        check("t5_restart_trig", 64'(triggered), 64'd0);
        check("t5_restart_count", 64'(entry_count), 64'd0);
        pulse_dump();
        tick(5);
        check("t5_dump_ignored", 64'(out_valid), 64'd0);
        check("t5_still_armed", 64'(armed), 64'd1);
        check("t5_not_done", 64'(done), 64'd0);

        // Reset asserted mid-dump
        for (int n = 0; n < 3; n++)
            bus_cycle(32'h5000 + 32'(4 * n), 32'h8888_0000 | 32'(n), 1'b0, 1'b0);
        check("t6_done", 64'(done), 64'd1);
        pulse_dump();
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick(1);
        check("t6_dumping", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_trig", 64'(triggered), 64'd0);
        check("t6_rst_count", 64'(entry_count), 64'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        pulse_dump();
        tick(4);
        check("t6_idle_no_dump", 64'(out_valid), 64'd0);
        check("t6_idle_not_armed", 64'(armed), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
